// File: rtl/operand_fetch_pkg.sv
// Shared RV32 decode helpers for the operand-fetch stage: opcode constants,
// instruction field slices and per-opcode source/destination usage.
package operand_fetch_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ARI_I  = 7'b0010011;
    localparam logic [6:0] OPC_ARI_R  = 7'b0110011;

    function automatic logic [6:0] opc_of(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    // Unknown opcodes are treated as reading rs1 so a load-use hazard is never missed.
    function automatic logic uses_rs1(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL:                               return 1'b0;
            OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_ARI_I,
            OPC_ARI_R:                                                 return 1'b1;
            default:                                                   return 1'b1;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        case (opc)
            OPC_ARI_R, OPC_STORE, OPC_BRANCH: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic has_rd(input logic [6:0] opc);
        case (opc)
            OPC_STORE, OPC_BRANCH: return 1'b0;
            default:               return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/operand_fetch_bypass_mux.sv
// Per-operand bypass mux: picks the youngest in-flight result for one source
// register, falling back to the register-file read data.
module operand_fetch_bypass_mux
    import operand_fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      addr,
    input  logic [XLEN-1:0] rf_val,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_wa,
    input  logic [XLEN-1:0] ex_wd,
    input  logic            mem_we,
    input  logic [4:0]      mem_wa,
    input  logic [XLEN-1:0] mem_wd,
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    output logic [XLEN-1:0] fwd_val
);

    // WB must be bypassed too: the register file does not write through.
    always_comb begin
        fwd_val = rf_val;
        if (addr == 5'd0) begin
            fwd_val = '0;
        end else if (ex_we && !ex_is_load && ex_wa == addr) begin
            fwd_val = ex_wd;
        end else if (mem_we && mem_wa == addr) begin
            fwd_val = mem_wd;
        end else if (wb_we && wb_wa == addr) begin
            fwd_val = wb_wd;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: register-file addressing, EX/MEM/WB bypass,
// load-use bubble insertion and the valid/ready pipeline register toward EX.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_inst,
    input  logic [XLEN-1:0]  if_pc,
    output logic [4:0]       rf_ra1,
    output logic [4:0]       rf_ra2,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    input  logic             ex_we,
    input  logic [4:0]       ex_wa,
    input  logic             ex_is_load,
    input  logic [XLEN-1:0]  ex_wd,
    input  logic             mem_we,
    input  logic [4:0]       mem_wa,
    input  logic [XLEN-1:0]  mem_wd,
    input  logic             wb_we,
    input  logic [4:0]       wb_wa,
    input  logic [XLEN-1:0]  wb_wd,
    input  logic             flush,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [31:0]      id_inst,
    output logic [XLEN-1:0]  id_rs1_val,
    output logic [XLEN-1:0]  id_rs2_val,
    output logic [4:0]       id_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [6:0]      opc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic            adv;
    logic            haz;

    assign opc    = opc_of(if_inst);
    assign rs1    = rs1_of(if_inst);
    assign rs2    = rs2_of(if_inst);
    assign rf_ra1 = rs1;
    assign rf_ra2 = rs2;

    operand_fetch_bypass_mux #(.XLEN(XLEN)) u_byp1 (
        .addr       (rs1),
        .rf_val     (rf_rd1),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_wa      (ex_wa),
        .ex_wd      (ex_wd),
        .mem_we     (mem_we),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .wb_we      (wb_we),
        .wb_wa      (wb_wa),
        .wb_wd      (wb_wd),
        .fwd_val    (fwd1)
    );

    operand_fetch_bypass_mux #(.XLEN(XLEN)) u_byp2 (
        .addr       (rs2),
        .rf_val     (rf_rd2),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_wa      (ex_wa),
        .ex_wd      (ex_wd),
        .mem_we     (mem_we),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .wb_we      (wb_we),
        .wb_wa      (wb_wa),
        .wb_wd      (wb_wd),
        .fwd_val    (fwd2)
    );

    assign adv = !id_valid || id_ready;
    assign haz = if_valid && ex_we && ex_is_load && (ex_wa != 5'd0) &&
                 ((uses_rs1(opc) && rs1 == ex_wa) || (uses_rs2(opc) && rs2 == ex_wa));

    // A flush accepts (and discards) the wrong-path word even when it would stall.
    assign if_ready = adv && (!haz || flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_inst    <= '0;
            id_rs1_val <= '0;
            id_rs2_val <= '0;
            id_rd      <= '0;
            stall_cnt  <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (adv) begin
            if (haz) begin
                id_valid <= 1'b0;
                if (stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end else begin
                id_valid   <= if_valid;
                id_pc      <= if_pc;
                id_inst    <= if_inst;
                id_rs1_val <= fwd1;
                id_rs2_val <= fwd2;
                id_rd      <= has_rd(opc) ? rd_of(if_inst) : 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed corner cases plus randomized
// traffic, checked against a behavioural model of the stage.
module tb_operand_fetch;

    localparam logic [6:0] M_LUI    = 7'b0110111;
    localparam logic [6:0] M_AUIPC  = 7'b0010111;
    localparam logic [6:0] M_JAL    = 7'b1101111;
    localparam logic [6:0] M_JALR   = 7'b1100111;
    localparam logic [6:0] M_BRANCH = 7'b1100011;
    localparam logic [6:0] M_LOAD   = 7'b0000011;
    localparam logic [6:0] M_STORE  = 7'b0100011;
    localparam logic [6:0] M_ARI_I  = 7'b0010011;
    localparam logic [6:0] M_ARI_R  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready;
    logic [31:0] if_inst, if_pc;
    logic [4:0]  rf_ra1, rf_ra2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        ex_we, ex_is_load;
    logic [4:0]  ex_wa;
    logic [31:0] ex_wd;
    logic        mem_we;
    logic [4:0]  mem_wa;
    logic [31:0] mem_wd;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        flush;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_inst, id_rs1_val, id_rs2_val;
    logic [4:0]  id_rd;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_we(ex_we), .ex_wa(ex_wa), .ex_is_load(ex_is_load), .ex_wd(ex_wd),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_rd(id_rd),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        iv;
        logic [31:0] inst, pc, rd1, rd2;
        logic        exwe, exld;
        logic [4:0]  exwa;
        logic [31:0] exwd;
        logic        memwe;
        logic [4:0]  memwa;
        logic [31:0] memwd;
        logic        wbwe;
        logic [4:0]  wbwa;
        logic [31:0] wbwd;
        logic        fl, idr;
    } stim_t;

    typedef struct {
        logic [31:0] pc, inst, rs1, rs2;
        logic [4:0]  rd;
    } exp_t;

    exp_t        q[$];
    logic [15:0] exp_stall = 16'd0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.iv = 1'b0; s.inst = 32'h0000_0013; s.pc = 32'h0; s.rd1 = 32'h0; s.rd2 = 32'h0;
        s.exwe = 1'b0; s.exld = 1'b0; s.exwa = 5'd0; s.exwd = 32'h0;
        s.memwe = 1'b0; s.memwa = 5'd0; s.memwd = 32'h0;
        s.wbwe = 1'b0; s.wbwa = 5'd0; s.wbwd = 32'h0;
        s.fl = 1'b0; s.idr = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] add_inst(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, M_ARI_R};
    endfunction

    // Reference model: stage behaviour stated as plain rules on opcode and fields.
    function automatic logic reads_rs1(input logic [6:0] op);
        return !(op == M_LUI || op == M_AUIPC || op == M_JAL);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op == M_ARI_R || op == M_STORE || op == M_BRANCH;
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] rf,
                                              input stim_t s);
        if (a == 5'd0) return 32'h0;
        if (s.exwe && !s.exld && s.exwa == a) return s.exwd;
        if (s.memwe && s.memwa == a) return s.memwd;
        if (s.wbwe && s.wbwa == a) return s.wbwd;
        return rf;
    endfunction

    function automatic logic model_haz(input stim_t s);
        logic [6:0] op;
        logic [4:0] r1, r2;
        op = s.inst[6:0];
        r1 = s.inst[19:15];
        r2 = s.inst[24:20];
        return s.iv && s.exwe && s.exld && s.exwa != 5'd0 &&
               ((reads_rs1(op) && r1 == s.exwa) || (reads_rs2(op) && r2 == s.exwa));
    endfunction

    task automatic apply(input stim_t s);
        if_valid = s.iv; if_inst = s.inst; if_pc = s.pc; rf_rd1 = s.rd1; rf_rd2 = s.rd2;
        ex_we = s.exwe; ex_is_load = s.exld; ex_wa = s.exwa; ex_wd = s.exwd;
        mem_we = s.memwe; mem_wa = s.memwa; mem_wd = s.memwd;
        wb_we = s.wbwe; wb_wa = s.wbwa; wb_wd = s.wbwd;
        flush = s.fl; id_ready = s.idr;
    endtask

    // One clock of stimulus; the model decides what the coming edge does.
    task automatic step(input stim_t s);
        logic busy, adv, haz;
        exp_t e;
        @(posedge clk);
        #2;
        apply(s);
        #1;
        busy = (q.size() != 0);
        adv  = !busy || s.idr;
        haz  = model_haz(s);
        chk("if_ready", {31'b0, if_ready}, {31'b0, adv && (!haz || s.fl)});
        chk("rf_ra1", {27'b0, rf_ra1}, {27'b0, s.inst[19:15]});
        chk("rf_ra2", {27'b0, rf_ra2}, {27'b0, s.inst[24:20]});
        @(negedge clk);
        #1;
        if (s.fl) begin
            if (busy && !s.idr && q.size() != 0) void'(q.pop_front());
        end else if (adv) begin
            if (haz) begin
                if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            end else if (s.iv) begin
                e.pc   = s.pc;
                e.inst = s.inst;
                e.rs1  = model_fwd(s.inst[19:15], s.rd1, s);
                e.rs2  = model_fwd(s.inst[24:20], s.rd2, s);
                e.rd   = (s.inst[6:0] == M_STORE || s.inst[6:0] == M_BRANCH) ? 5'd0 : s.inst[11:7];
                q.push_back(e);
            end
        end
    endtask

    // Monitor: whatever the DUT presents is compared against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, exp_stall});
                if (q.size() == 0) begin
                    chk("id_valid_idle", {31'b0, id_valid}, 32'd0);
                end else begin
                    chk("id_valid", {31'b0, id_valid}, 32'd1);
                    chk("id_pc", id_pc, q[0].pc);
                    chk("id_inst", id_inst, q[0].inst);
                    chk("id_rs1_val", id_rs1_val, q[0].rs1);
                    chk("id_rs2_val", id_rs2_val, q[0].rs2);
                    chk("id_rd", {27'b0, id_rd}, {27'b0, q[0].rd});
                    if (id_ready) void'(q.pop_front());
                end
            end
        end
    end

    function automatic stim_t rand_stim();
        stim_t s;
        logic [6:0] ops [9];
        logic [31:0] r;
        ops = '{M_LUI, M_AUIPC, M_JAL, M_JALR, M_BRANCH, M_LOAD, M_STORE, M_ARI_I, M_ARI_R};
        r = $urandom();
        s.inst  = {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[14:12],
                   5'($urandom_range(0, 7)), ops[$urandom_range(0, 8)]};
        s.iv    = ($urandom_range(0, 9) < 8);
        s.pc    = $urandom() & 32'hFFFF_FFFC;
        s.rd1   = $urandom();
        s.rd2   = $urandom();
        s.exwe  = $urandom_range(0, 1) == 1;
        s.exld  = $urandom_range(0, 2) == 0;
        s.exwa  = 5'($urandom_range(0, 7));
        s.exwd  = $urandom();
        s.memwe = $urandom_range(0, 1) == 1;
        s.memwa = 5'($urandom_range(0, 7));
        s.memwd = $urandom();
        s.wbwe  = $urandom_range(0, 1) == 1;
        s.wbwa  = 5'($urandom_range(0, 7));
        s.wbwd  = $urandom();
        s.fl    = $urandom_range(0, 9) == 0;
        s.idr   = $urandom_range(0, 3) != 0;
        return s;
    endfunction

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        stim_t s;
        logic [15:0] st0;
        rst_n = 1'b0;
        apply(idle());
        repeat (3) @(posedge clk);
        #1;
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        chk("rst_id_rs1", id_rs1_val, 32'd0);
        chk("rst_id_rs2", id_rs2_val, 32'd0);
        chk("rst_id_rd", {27'b0, id_rd}, 32'd0);
        chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        #1 rst_n = 1'b1;
        step(idle());

        // Load-use: stall, then issue once the load leaves EX.
        s = idle(); s.iv = 1'b1; s.inst = add_inst(5'd1, 5'd4, 5'd2); s.pc = 32'h100;
        s.exwe = 1'b1; s.exld = 1'b1; s.exwa = 5'd4;
        step(s);
        s.exwe = 1'b0; s.rd1 = 32'h44; s.rd2 = 32'h22;
        step(s);
        chk("lu_bubble_valid", {31'b0, id_valid}, 32'd0);
        chk("lu_stall_cnt", {16'b0, stall_cnt}, 32'd1);
        step(idle());
        chk("lu_issue_valid", {31'b0, id_valid}, 32'd1);
        chk("lu_issue_rs1", id_rs1_val, 32'h44);

        // LUI does not read rs1: no stall.
        s = idle(); s.iv = 1'b1; s.inst = {20'h00001, 5'd4, M_LUI}; s.pc = 32'h104;
        s.exwe = 1'b1; s.exld = 1'b1; s.exwa = 5'd4;
        step(s);
        step(idle());
        chk("lui_valid", {31'b0, id_valid}, 32'd1);
        chk("lui_stall_cnt", {16'b0, stall_cnt}, 32'd1);

        // x0 is never forwarded, even from a WB write to x0.
        s = idle(); s.iv = 1'b1; s.inst = add_inst(5'd5, 5'd0, 5'd0); s.rd1 = 32'hDEAD_BEEF;
        s.wbwe = 1'b1; s.wbwa = 5'd0; s.wbwd = 32'hFFFF_FFFF;
        step(s);
        step(idle());
        chk("x0_rs1", id_rs1_val, 32'd0);

        // WB bypass over a stale register-file read.
        s = idle(); s.iv = 1'b1; s.inst = add_inst(5'd3, 5'd1, 5'd2); s.rd1 = 32'd0;
        s.wbwe = 1'b1; s.wbwa = 5'd1; s.wbwd = 32'h0000_1234;
        step(s);
        step(idle());
        chk("wb_bypass_rs1", id_rs1_val, 32'h0000_1234);

        // EX beats MEM beats WB.
        s = idle(); s.iv = 1'b1; s.inst = add_inst(5'd3, 5'd1, 5'd7);
        s.exwe = 1'b1; s.exwa = 5'd7; s.exwd = 32'hA;
        s.memwe = 1'b1; s.memwa = 5'd7; s.memwd = 32'hB;
        s.wbwe = 1'b1; s.wbwa = 5'd7; s.wbwd = 32'hC;
        step(s);
        s.exwe = 1'b0;
        step(s);
        chk("prio_ex", id_rs2_val, 32'hA);
        step(idle());
        chk("prio_mem", id_rs2_val, 32'hB);

        // Backpressure for three cycles, then flush during the hold.
        s = idle(); s.iv = 1'b1; s.inst = add_inst(5'd9, 5'd2, 5'd3); s.pc = 32'h200;
        s.rd1 = 32'h1111; s.rd2 = 32'h2222;
        step(s);
        s.pc = 32'h204; s.inst = add_inst(5'd10, 5'd4, 5'd5); s.idr = 1'b0;
        repeat (3) step(s);
        chk("hold_pc", id_pc, 32'h200);
        s.fl = 1'b1;
        step(s);
        step(idle());
        chk("flush_hold_valid", {31'b0, id_valid}, 32'd0);

        for (int i = 0; i < 400; i++) step(rand_stim());

        // Asynchronous reset mid-run takes effect before the next edge.
        st0 = exp_stall;
        @(posedge clk);
        #2;
        apply(idle());
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, id_valid}, 32'd0);
        chk("async_rst_stall", {16'b0, stall_cnt}, 32'd0);
        q.delete();
        exp_stall = 16'd0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        if (st0 == 16'd0) $display("note: no stalls seen before mid-run reset");

        for (int i = 0; i < 100; i++) step(rand_stim());
        step(idle());
        step(idle());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
